dmp_domain_unit: RTL and testbench

Parametrised JITDomain domain-memory-protection unit: holds NR_ENTRIES TOR-style regions, each tagged with a domain, plus the hart's current-domain register. It checks physical addresses against the current domain with a one-cycle registered response and tracks allowed accesses still in flight. It also runs a drain-then-switch state machine so the current domain never changes while allowed accesses are outstanding. It sits beside the PMP in the load/store and fetch path and is written via the DMP CSRs.

---
 rtl/dmp_domain_unit.sv | 177 +++++++++++++++++
 tb/tb_dmp_domain_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmp_domain_unit.sv
// JITDomain domain-memory-protection unit: domain-tagged TOR regions, registered checks, drain-then-switch FSM.
// Build macro DMP_SHARED_DOMAIN_EN makes the all-ones domain accessible from every current domain.
module dmp_domain_unit #(
    parameter int unsigned NR_ENTRIES = 8,
    parameter int unsigned DOM_W      = 2,
    parameter int unsigned PLEN       = 34,
    parameter int unsigned MAX_OUTST  = 4
) (
    input  logic                                                   clk_i,
    input  logic                                                   rst_i,
    input  logic                                                   csr_we_i,
    input  logic                                                   csr_sel_i,
    input  logic [((NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1)-1:0] csr_idx_i,
    input  logic [PLEN-3:0]                                        csr_wdata_i,
    output logic [PLEN-3:0]                                        csr_rdata_o,
    input  logic                                                   switch_req_i,
    input  logic [DOM_W-1:0]                                       switch_dom_i,
    output logic                                                   switch_ack_o,
    output logic [DOM_W-1:0]                                       cur_dom_o,
    input  logic                                                   chk_valid_i,
    output logic                                                   chk_ready_o,
    input  logic [PLEN-1:0]                                        chk_addr_i,
    output logic                                                   chk_rvalid_o,
    output logic                                                   chk_allow_o,
    input  logic                                                   txn_done_i
);

    localparam int unsigned AW    = PLEN - 2;
    localparam int unsigned CFG_W = DOM_W + 2;
    localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);

    typedef logic [AW-1:0]    word_t;
    typedef logic [CFG_W-1:0] cfg_t;
    typedef enum logic [1:0] {IDLE, DRAIN, SWITCH} state_e;

    word_t            addr_q [NR_ENTRIES];
    word_t            addr_d [NR_ENTRIES];
    cfg_t             cfg_q  [NR_ENTRIES];
    cfg_t             cfg_d  [NR_ENTRIES];
    word_t            base   [NR_ENTRIES];
    logic             tor_lock [NR_ENTRIES];
    word_t            rdata_q, rdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rvalid_q, allow_q;
    state_e           state_q;
    logic [DOM_W-1:0] tgt_q, cur_dom_q;
    logic             ack_q;

    logic             idx_ok;
    logic             accept;
    logic             hit, shared_hit, allow_c;
    logic [DOM_W-1:0] hit_dom;
    word_t            chk_word;
    logic             unused_addr_lsb;

    assign chk_word        = chk_addr_i[PLEN-1:2];
    assign unused_addr_lsb = ^chk_addr_i[1:0];
    assign idx_ok          = 32'(csr_idx_i) < NR_ENTRIES;

    // TOR base of entry i is addr[i-1]; entry i+1's lock also protects addr[i].
    always_comb begin
        for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
            base[i]     = '0;
            tor_lock[i] = 1'b0;
        end
        for (int unsigned i = 1; i < NR_ENTRIES; i++) begin
            base[i]       = addr_q[i-1];
            tor_lock[i-1] = cfg_q[i][CFG_W-1];
        end
    end

    always_comb begin
        addr_d = addr_q;
        cfg_d  = cfg_q;
        if (csr_we_i && idx_ok && !cfg_q[csr_idx_i][CFG_W-1]) begin
            if (csr_sel_i) begin
                cfg_d[csr_idx_i] = csr_wdata_i[CFG_W-1:0];
            end else if (!tor_lock[csr_idx_i]) begin
                addr_d[csr_idx_i] = csr_wdata_i;
            end
        end
    end

    // Readback uses the post-write value so a write is visible on the next cycle.
    always_comb begin
        rdata_d = '0;
        if (idx_ok) begin
            rdata_d = csr_sel_i ? AW'(cfg_d[csr_idx_i]) : addr_d[csr_idx_i];
        end
    end

    always_comb begin
        hit     = 1'b0;
        hit_dom = '0;
        for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
            if (!hit && (chk_word >= base[i]) && (chk_word < addr_q[i])) begin
                hit     = 1'b1;
                hit_dom = cfg_q[i][DOM_W-1:0];
            end
        end
    end

`ifdef DMP_SHARED_DOMAIN_EN
    assign shared_hit = (hit_dom == '1);
`else
    assign shared_hit = 1'b0;
`endif

    assign allow_c     = !hit || (hit_dom == cur_dom_q) || shared_hit;
    assign chk_ready_o = (state_q == IDLE) && (cnt_q < CNT_W'(MAX_OUTST));
    assign accept      = chk_valid_i && chk_ready_o;

    always_comb begin
        cnt_d = cnt_q;
        if ((accept && allow_c) && !(txn_done_i && (cnt_q != '0))) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!(accept && allow_c) && txn_done_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
                addr_q[i] <= '0;
                cfg_q[i]  <= '0;
            end
            rdata_q  <= '0;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            allow_q  <= 1'b0;
        end else begin
            addr_q   <= addr_d;
            cfg_q    <= cfg_d;
            rdata_q  <= rdata_d;
            cnt_q    <= cnt_d;
            rvalid_q <= accept;
            allow_q  <= accept && allow_c;
        end
    end

    // Domain and ack are registered on the DRAIN->SWITCH edge so both appear in the SWITCH cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            tgt_q     <= '0;
            cur_dom_q <= '0;
            ack_q     <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (switch_req_i) begin
                        tgt_q   <= switch_dom_i;
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if ((cnt_q == '0) && !rvalid_q) begin
                        cur_dom_q <= tgt_q;
                        ack_q     <= 1'b1;
                        state_q   <= SWITCH;
                    end
                end
                SWITCH: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign csr_rdata_o  = rdata_q;
    assign switch_ack_o = ack_q;
    assign cur_dom_o    = cur_dom_q;
    assign chk_rvalid_o = rvalid_q;
    assign chk_allow_o  = allow_q;

endmodule

// File: tb/tb_dmp_domain_unit.sv
// Directed, table-driven bench for dmp_domain_unit (default parameters).
module tb_dmp_domain_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        csr_we, csr_sel;
    logic [2:0]  csr_idx;
    logic [31:0] csr_wdata, csr_rdata;
    logic        switch_req, switch_ack;
    logic [1:0]  switch_dom, cur_dom;
    logic        chk_valid, chk_ready, chk_rvalid, chk_allow, txn_done;
    logic [33:0] chk_addr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmp_domain_unit #(.NR_ENTRIES(8), .DOM_W(2), .PLEN(34), .MAX_OUTST(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .csr_we_i(csr_we), .csr_sel_i(csr_sel), .csr_idx_i(csr_idx),
        .csr_wdata_i(csr_wdata), .csr_rdata_o(csr_rdata),
        .switch_req_i(switch_req), .switch_dom_i(switch_dom),
        .switch_ack_o(switch_ack), .cur_dom_o(cur_dom),
        .chk_valid_i(chk_valid), .chk_ready_o(chk_ready), .chk_addr_i(chk_addr),
        .chk_rvalid_o(chk_rvalid), .chk_allow_o(chk_allow), .txn_done_i(txn_done)
    );

    typedef struct {
        logic        we;
        logic        sel;
        logic [2:0]  idx;
        logic [31:0] wd;
        logic        cv;
        logic [33:0] ca;
        logic        done;
        logic        rv;
        logic        al;
        logic [31:0] rd;
        logic        rdy;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t V(logic we, logic sel, logic [2:0] idx, logic [31:0] wd,
                               logic cv, logic [33:0] ca, logic done,
                               logic rv, logic al, logic [31:0] rd, logic rdy);
        vec_t r;
        r.we = we; r.sel = sel; r.idx = idx; r.wd = wd; r.cv = cv; r.ca = ca;
        r.done = done; r.rv = rv; r.al = al; r.rd = rd; r.rdy = rdy;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        csr_we = 0; csr_sel = 0; csr_idx = 0; csr_wdata = 0;
        switch_req = 0; switch_dom = 0;
        chk_valid = 0; chk_addr = 0; txn_done = 0;
    endtask

    task automatic csr_write(input logic sel, input logic [2:0] idx, input logic [31:0] wd,
                             input logic [31:0] exp_rd, input string name);
        csr_we = 1; csr_sel = sel; csr_idx = idx; csr_wdata = wd;
        step();
        csr_we = 0;
        chk(name, csr_rdata, exp_rd);
    endtask

    task automatic do_chk(input logic [33:0] a, input logic exp_allow, input string name);
        chk_valid = 1; chk_addr = a;
        step();
        chk_valid = 0;
        chk({name, "_rvalid"}, chk_rvalid, 1);
        chk({name, "_allow"}, chk_allow, exp_allow);
    endtask

    task automatic done_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            txn_done = 1;
            step();
        end
        txn_done = 0;
    endtask

    task automatic do_switch(input logic [1:0] d, input string name);
        switch_req = 1; switch_dom = d;
        step();
        chk({name, "_drain_ack"}, switch_ack, 0);
        chk({name, "_drain_ready"}, chk_ready, 0);
        step();
        switch_req = 0;
        chk({name, "_ack"}, switch_ack, 1);
        chk({name, "_dom"}, cur_dom, d);
        chk({name, "_sw_ready"}, chk_ready, 0);
        step();
        chk({name, "_ack_clear"}, switch_ack, 0);
        chk({name, "_ready_back"}, chk_ready, 1);
    endtask

    logic exp_shared;

    initial begin
`ifdef DMP_SHARED_DOMAIN_EN
        exp_shared = 1'b1;
`else
        exp_shared = 1'b0;
`endif
        clear_inputs();
        rst = 1;
        step();
        step();
        chk("rst_dom", cur_dom, 0);
        chk("rst_rdata", csr_rdata, 0);
        chk("rst_ack", switch_ack, 0);
        chk("rst_rvalid", chk_rvalid, 0);
        chk("rst_allow", chk_allow, 0);
        chk("rst_ready", chk_ready, 1);
        rst = 0;
        step();

        //        we sel idx wd        cv ca          dn  rv al rd         rdy
        tv.push_back(V(0, 0, 0, 32'h0,   0, 34'h0,    0,  0, 0, 32'h0,   1));
        tv.push_back(V(1, 0, 0, 32'h100, 0, 34'h0,    0,  0, 0, 32'h100, 1));
        tv.push_back(V(1, 1, 0, 32'h1,   1, 34'h200,  0,  1, 1, 32'h1,   1));
        tv.push_back(V(0, 1, 0, 32'h0,   1, 34'h200,  0,  1, 0, 32'h1,   1));
        tv.push_back(V(0, 0, 0, 32'h0,   1, 34'h1000, 0,  1, 1, 32'h100, 1));
        tv.push_back(V(0, 0, 0, 32'h0,   1, 34'h1000, 1,  1, 1, 32'h100, 1));
        tv.push_back(V(0, 0, 0, 32'h0,   1, 34'h1000, 0,  1, 1, 32'h100, 1));
        tv.push_back(V(0, 0, 0, 32'h0,   1, 34'h1000, 0,  1, 1, 32'h100, 0));
        tv.push_back(V(0, 0, 0, 32'h0,   1, 34'h1000, 0,  0, 0, 32'h100, 0));
        for (int i = 0; i < 5; i++)
            tv.push_back(V(0, 0, 0, 32'h0, 0, 34'h0,  1,  0, 0, 32'h100, 1));
        for (int i = 0; i < 4; i++)
            tv.push_back(V(0, 0, 0, 32'h0, 1, 34'h1000, 0, 1, 1, 32'h100, (i < 3) ? 1'b1 : 1'b0));
        for (int i = 0; i < 4; i++)
            tv.push_back(V(0, 0, 0, 32'h0, 0, 34'h0,  1,  0, 0, 32'h100, 1));
        tv.push_back(V(0, 0, 0, 32'h0,   1, 34'h3FC,  0,  1, 0, 32'h100, 1));
        tv.push_back(V(0, 0, 0, 32'h0,   1, 34'h400,  0,  1, 1, 32'h100, 1));
        tv.push_back(V(0, 0, 0, 32'h0,   0, 34'h0,    1,  0, 0, 32'h100, 1));
        tv.push_back(V(0, 0, 7, 32'h0,   0, 34'h0,    0,  0, 0, 32'h0,   1));

        foreach (tv[k]) begin
            csr_we = tv[k].we; csr_sel = tv[k].sel; csr_idx = tv[k].idx; csr_wdata = tv[k].wd;
            chk_valid = tv[k].cv; chk_addr = tv[k].ca; txn_done = tv[k].done;
            step();
            chk($sformatf("vec%0d_rvalid", k), chk_rvalid, tv[k].rv);
            if (tv[k].rv) chk($sformatf("vec%0d_allow", k), chk_allow, tv[k].al);
            chk($sformatf("vec%0d_rdata", k), csr_rdata, tv[k].rd);
            chk($sformatf("vec%0d_ready", k), chk_ready, tv[k].rdy);
        end
        clear_inputs();

        do_switch(2'd1, "sw1");
        do_chk(34'h200, 1, "dom1_own");
        do_chk(34'h1000, 1, "dom1_nomatch");
        done_pulses(2);

        for (int i = 0; i < 4; i++) begin
            chk("drain_fill_ready", chk_ready, 1);
            do_chk(34'h200, 1, "drain_fill");
        end
        chk("drain_full_ready", chk_ready, 0);
        switch_req = 1; switch_dom = 2'd0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("drain_wait_ack", switch_ack, 0);
        end
        for (int i = 0; i < 4; i++) begin
            txn_done = 1;
            step();
            chk("drain_done_ack", switch_ack, 0);
        end
        txn_done = 0;
        step();
        chk("drain_ack", switch_ack, 1);
        chk("drain_dom", cur_dom, 0);
        switch_req = 0;
        step();
        chk("drain_ack_clear", switch_ack, 0);
        chk("drain_ready_back", chk_ready, 1);

        do_switch(2'd1, "sw1b");
        csr_write(0, 1, 32'h200, 32'h200, "wr_addr1");
        csr_write(0, 2, 32'h300, 32'h300, "wr_addr2");
        csr_write(1, 2, 32'h3, 32'h3, "wr_cfg2");
        do_chk(34'hA00, exp_shared, "shared_mid");
        do_chk(34'h800, exp_shared, "shared_lo_edge");
        do_chk(34'h7FC, 0, "region1_dom0");
        done_pulses(3);

        csr_write(1, 1, 32'h8, 32'h8, "lock_cfg1");
        csr_write(0, 0, 32'h555, 32'h100, "locked_addr0");
        csr_write(0, 1, 32'h666, 32'h200, "locked_addr1");
        csr_write(1, 1, 32'h0, 32'h8, "locked_cfg1");
        csr_write(0, 2, 32'h777, 32'h777, "free_addr2");
        csr_write(1, 3, 32'h6, 32'h6, "reserved_bit");
        csr_write(1, 4, 32'hF5, 32'h5, "cfg_width");
        rst = 1;
        step();
        rst = 0;
        csr_sel = 1; csr_idx = 1;
        step();
        chk("post_rst_cfg1", csr_rdata, 0);
        chk("post_rst_dom", cur_dom, 0);
        clear_inputs();

        do_switch(2'd2, "sw2");
        do_chk(34'h1000, 1, "pre_rst_chk");
        switch_req = 1; switch_dom = 2'd3;
        step();
        chk("rst_drain_ack", switch_ack, 0);
        chk("rst_drain_ready", chk_ready, 0);
        step();
        chk("rst_drain_hold", switch_ack, 0);
        chk("rst_drain_dom", cur_dom, 2);
        #2;
        rst = 1;
        switch_req = 0;
        #1;
        chk("async_rst_dom", cur_dom, 0);
        chk("async_rst_ready", chk_ready, 1);
        step();
        rst = 0;
        step();
        chk("after_rst_ack", switch_ack, 0);
        chk("after_rst_dom", cur_dom, 0);
        chk("after_rst_ready", chk_ready, 1);
        step();
        chk("after_rst_ack2", switch_ack, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
